// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - word-to-serial sequencer with overlapping Mealy pattern detector
module seq_det_sched #(
  parameter int W    = 8,
  parameter int PLEN = 4,
  parameter int CW   = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CFG_WE,
  input  logic [PLEN-1:0] CFG_PAT,
  input  logic [CW-1:0]   CFG_THR,
  input  logic            IN_VALID,
  input  logic [W-1:0]    IN_DATA,
  output logic            IN_READY,
  output logic            BIT_OUT,
  output logic            BIT_VALID,
  output logic            MATCH,
  output logic [CW-1:0]   MATCH_CNT,
  output logic            IRQ,
  input  logic            CLR_IRQ,
  output logic            BUSY
);

  localparam int CNTW = $clog2(W);
  localparam int HLW  = $clog2(PLEN);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(W - 1);
  localparam logic [HLW-1:0]  HLEN_MAX = HLW'(PLEN - 1);
  localparam logic [CW-1:0]   CNT_SAT  = '1;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PLEN-1:0] pat_q;
  logic [CW-1:0]   thr_q;
  logic [PLEN-2:0] hist_q;
  logic [HLW-1:0]  hlen_q;
  logic [CW-1:0]   mcnt_q;
  logic            irq_q;

  logic            accept;
  logic            cfg_ok;
  logic [PLEN-1:0] hist_cat;
  logic [CW-1:0]   mcnt_inc;
  logic            cnt_hit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          sr_d    = IN_DATA;
          cnt_d   = CNT_LAST;
        end
      end
      S_SHIFT: begin
        sr_d = {sr_q[W-2:0], 1'b0};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else if (accept) begin
          sr_d  = IN_DATA;
          cnt_d = CNT_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = 1'b1;
    BIT_VALID = 1'b0;
    BIT_OUT   = 1'b0;
    BUSY      = 1'b0;
    if (state_q == S_SHIFT) begin
      IN_READY  = (cnt_q == '0);
      BIT_VALID = 1'b1;
      BIT_OUT   = sr_q[W-1];
      BUSY      = 1'b1;
    end
  end

  assign accept    = IN_VALID & IN_READY;
  assign cfg_ok    = CFG_WE & (state_q == S_IDLE);
  assign hist_cat  = {hist_q, BIT_OUT};
  assign MATCH     = BIT_VALID & (hlen_q == HLEN_MAX) & (hist_cat == pat_q);
  assign mcnt_inc  = mcnt_q + CW'(1);
  // A saturated counter neither advances nor can re-trigger the interrupt.
  assign cnt_hit   = MATCH & (mcnt_q != CNT_SAT);
  assign MATCH_CNT = mcnt_q;
  assign IRQ       = irq_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      pat_q  <= '0;
      thr_q  <= '0;
      hist_q <= '0;
      hlen_q <= '0;
      mcnt_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      if (cfg_ok) begin
        pat_q  <= CFG_PAT;
        thr_q  <= CFG_THR;
        hist_q <= '0;
        hlen_q <= '0;
        mcnt_q <= '0;
        irq_q  <= 1'b0;
      end else begin
        if (BIT_VALID) begin
          hist_q <= hist_cat[PLEN-2:0];
          if (hlen_q != HLEN_MAX) hlen_q <= hlen_q + HLW'(1);
        end
        if (cnt_hit) mcnt_q <= mcnt_inc;
        if (cnt_hit && (thr_q != '0) && (mcnt_inc == thr_q)) irq_q <= 1'b1;
        else if (CLR_IRQ)                                    irq_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// tb/tb_seq_det_sched.sv - scoreboard bench for seq_det_sched
module tb_seq_det_sched;

  logic       clk, rst_n;
  logic       cfg_we, in_valid, clr_irq;
  logic [3:0] cfg_pat;
  logic [7:0] cfg_thr, in_data, match_cnt;
  logic       in_ready, bit_out, bit_valid, match, irq, busy;

  logic       cfg_we2, in_valid2, clr_irq2;
  logic [1:0] cfg_pat2, cfg_thr2, match_cnt2;
  logic [7:0] in_data2;
  logic       in_ready2, bit_out2, bit_valid2, match2, irq2, busy2;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];
  logic [2:0] m_hist;
  int         m_hlen;
  logic [3:0] m_pat;
  int         m_cnt;

  seq_det_sched #(.W(8), .PLEN(4), .CW(8)) dut (
    .CLK(clk), .RST_N(rst_n), .CFG_WE(cfg_we), .CFG_PAT(cfg_pat), .CFG_THR(cfg_thr),
    .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(in_ready), .BIT_OUT(bit_out),
    .BIT_VALID(bit_valid), .MATCH(match), .MATCH_CNT(match_cnt), .IRQ(irq),
    .CLR_IRQ(clr_irq), .BUSY(busy)
  );

  seq_det_sched #(.W(8), .PLEN(2), .CW(2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .CFG_WE(cfg_we2), .CFG_PAT(cfg_pat2), .CFG_THR(cfg_thr2),
    .IN_VALID(in_valid2), .IN_DATA(in_data2), .IN_READY(in_ready2), .BIT_OUT(bit_out2),
    .BIT_VALID(bit_valid2), .MATCH(match2), .MATCH_CNT(match_cnt2), .IRQ(irq2),
    .CLR_IRQ(clr_irq2), .BUSY(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_word(input logic [7:0] d);
    logic b, m;
    for (int i = 7; i >= 0; i--) begin
      b = d[i];
      m = (m_hlen == 3) && ({m_hist, b} == m_pat);
      exp_q.push_back({b, m});
      if (m && m_cnt < 255) m_cnt++;
      m_hist = {m_hist[1:0], b};
      if (m_hlen < 3) m_hlen++;
    end
  endtask

  task automatic model_cfg(input logic [3:0] p);
    m_pat  = p;
    m_hist = '0;
    m_hlen = 0;
    m_cnt  = 0;
  endtask

  task automatic step();
    logic [1:0] e;
    @(negedge clk);
    total++;
    if (bit_valid) begin
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_bit: bit=%0b match=%0b with no expected bit pending", bit_out, match);
      end else begin
        e = exp_q.pop_front();
        if ({bit_out, match} !== e) begin
          bad++;
          $display("FAIL bit_match: got bit=%0b match=%0b, expected bit=%0b match=%0b",
                   bit_out, match, e[1], e[0]);
        end
      end
    end else if (match !== 1'b0) begin
      bad++;
      $display("FAIL idle_match: match=%0b while BIT_VALID low, expected 0", match);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [3:0] p, input logic [7:0] t);
    cfg_we = 1'b1; cfg_pat = p; cfg_thr = t;
    model_cfg(p);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic check_end(input string name, input int cnt, input logic irq_exp);
    total++;
    if (match_cnt !== 8'(cnt)) begin
      bad++;
      $display("FAIL %s_cnt: got %0d, expected %0d", name, match_cnt, cnt);
    end
    total++;
    if (irq !== irq_exp) begin
      bad++;
      $display("FAIL %s_irq: got %0b, expected %0b", name, irq, irq_exp);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d expected bits never presented, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_we = 0; cfg_pat = 0; cfg_thr = 0; in_valid = 0; in_data = 0; clr_irq = 0;
    cfg_we2 = 0; cfg_pat2 = 0; cfg_thr2 = 0; in_valid2 = 0; in_data2 = 0; clr_irq2 = 0;
    model_cfg(4'b0000);
    #12;
    total++;
    if ({in_ready, bit_valid, bit_out, match, busy, irq} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_outs: got rdy/bv/bo/m/busy/irq=%b, expected 100000",
               {in_ready, bit_valid, bit_out, match, busy, irq});
    end
    total++;
    if (match_cnt !== 8'd0 || in_ready2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_cnt: got cnt=%0d rdy2=%0b, expected 0 and 1", match_cnt, in_ready2);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    do_cfg(4'b1011, 8'd0);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_ready: got %0b, expected 1", in_ready);
    end
    in_valid = 1'b1; in_data = 8'b1011_0110;
    push_word(in_data);
    step();
    in_valid = 1'b0; in_data = 8'h49;
    repeat (8) step();
    check_end("basic", 2, 1'b0);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy: got %0b, expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    do_cfg(4'b1011, 8'd0);
    in_valid = 1'b1; in_data = 8'b0000_0101;
    push_word(in_data);
    step();
    in_data = 8'b1000_0000;
    push_word(in_data);
    for (int i = 1; i <= 16; i++) begin
      if (i == 9) in_valid = 1'b0;
      total++;
      if (busy !== 1'b1 || in_ready !== (i == 8 || i == 16)) begin
        bad++;
        $display("FAIL b2b_cycle%0d: got busy=%0b ready=%0b, expected busy=1 ready=%0b",
                 i, busy, in_ready, (i == 8 || i == 16));
      end
      step();
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_busy_end: got %0b, expected 0", busy);
    end
    check_end("b2b", 1, 1'b0);
  endtask

  task automatic test_threshold();
    do_cfg(4'b1011, 8'd3);
    in_valid = 1'b1; in_data = 8'b1011_0110;
    push_word(in_data);
    step();
    in_data = 8'b0000_1011;
    push_word(in_data);
    for (int i = 1; i <= 16; i++) begin
      if (i == 9) in_valid = 1'b0;
      if (i == 16) clr_irq = 1'b1;
      total++;
      if (irq !== 1'b0) begin
        bad++;
        $display("FAIL thr_early_irq%0d: got %0b, expected 0", i, irq);
      end
      step();
      clr_irq = 1'b0;
    end
    check_end("thr", 3, 1'b1);
    repeat (2) step();
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL thr_sticky: got %0b, expected 1", irq);
    end
    clr_irq = 1'b1;
    step();
    clr_irq = 1'b0;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL thr_clear: got %0b, expected 0", irq);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] w;
    int         ec;
    w = 8'b0011_1111;
    cfg_we2 = 1'b1; cfg_pat2 = 2'b11; cfg_thr2 = 2'd3;
    step();
    cfg_we2 = 1'b0;
    in_valid2 = 1'b1; in_data2 = w;
    step();
    in_valid2 = 1'b0; in_data2 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ec = (i <= 3) ? 0 : ((i - 3 > 3) ? 3 : i - 3);
      total++;
      if (bit_valid2 !== 1'b1 || bit_out2 !== w[7-i] || match2 !== (i >= 3)) begin
        bad++;
        $display("FAIL sat_bit%0d: got bv=%0b bit=%0b match=%0b, expected 1 %0b %0b",
                 i, bit_valid2, bit_out2, match2, w[7-i], (i >= 3));
      end
      total++;
      if (match_cnt2 !== 2'(ec) || irq2 !== (i == 6)) begin
        bad++;
        $display("FAIL sat_cnt%0d: got cnt=%0d irq=%0b, expected %0d %0b",
                 i, match_cnt2, irq2, ec, (i == 6));
      end
      if (i == 6) clr_irq2 = 1'b1;
      step();
      clr_irq2 = 1'b0;
    end
    total++;
    if (match_cnt2 !== 2'd3 || irq2 !== 1'b0) begin
      bad++;
      $display("FAIL sat_end: got cnt=%0d irq=%0b, expected 3 0", match_cnt2, irq2);
    end
  endtask

  task automatic test_cfg_gating();
    do_cfg(4'b1011, 8'd2);
    in_valid = 1'b1; in_data = 8'b1011_0110;
    push_word(in_data);
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        cfg_we = 1'b1; cfg_pat = 4'b0000; cfg_thr = 8'd5;
      end
      step();
      cfg_we = 1'b0;
    end
    check_end("gate_shift", 2, 1'b1);
    cfg_we = 1'b1; cfg_pat = 4'b1100; cfg_thr = 8'd0;
    in_valid = 1'b1; in_data = 8'b0110_0000;
    model_cfg(4'b1100);
    push_word(in_data);
    step();
    cfg_we = 1'b0; in_valid = 1'b0;
    total++;
    if (match_cnt !== 8'd0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL gate_idle_clear: got cnt=%0d irq=%0b, expected 0 0", match_cnt, irq);
    end
    repeat (8) step();
    check_end("gate_idle", 1, 1'b0);
  endtask

  task automatic test_async_reset();
    do_cfg(4'b1011, 8'd0);
    in_valid = 1'b1; in_data = 8'b1011_0110;
    push_word(in_data);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, bit_valid, bit_out, match, busy, irq} !== 6'b100000 || match_cnt !== 8'd0) begin
      bad++;
      $display("FAIL async_outs: got rdy/bv/bo/m/busy/irq=%b cnt=%0d, expected 100000 0",
               {in_ready, bit_valid, bit_out, match, busy, irq}, match_cnt);
    end
    #3 rst_n = 1'b1;
    exp_q.delete();
    model_cfg(4'b0000);
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_ready: got %0b, expected 1", in_ready);
    end
    in_valid = 1'b1; in_data = 8'h00;
    push_word(in_data);
    step();
    in_valid = 1'b0;
    repeat (8) step();
    check_end("async", 5, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_threshold();
    test_saturation();
    test_cfg_gating();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
